// File: rtl/hwag_pkg.sv
// Shared types and default sizes for the HWAG crank-wheel synchroniser.
// Tooth index is 0 for the first tooth after the missing-tooth gap.
package hwag_pkg;

  localparam int HWAG_WIDTH   = 24;
  localparam int HWAG_TOOTH_W = 6;
  localparam int HWAG_TEETH   = 58;

  localparam int HIST_W   = 2;
  localparam int HIST_MAX = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    VERIFY,
    LOCKED
  } hwag_state_t;

endpackage

// File: rtl/hwag_gap_sync_if.sv
// Sensor/control inputs and sync status outputs of the gap synchroniser.
// The master side drives edges and period limits; the slave side is the synchroniser.
interface hwag_gap_sync_if
  import hwag_pkg::*;
#(
  parameter int WIDTH   = HWAG_WIDTH,
  parameter int TOOTH_W = HWAG_TOOTH_W
);

  logic               enable;
  logic               cap_edge;
  logic [WIDTH-1:0]   min_period;
  logic [WIDTH-1:0]   max_period;
  logic [WIDTH-1:0]   period;
  logic [TOOTH_W-1:0] tooth_num;
  logic               gap_pulse;
  logic               locked;
  logic               stall;
  logic               err;

  modport master (
    output enable, cap_edge, min_period, max_period,
    input  period, tooth_num, gap_pulse, locked, stall, err
  );

  modport slave (
    input  enable, cap_edge, min_period, max_period,
    output period, tooth_num, gap_pulse, locked, stall, err
  );

endinterface

// File: rtl/hwag_cap_history.sv
// Tooth-period timer, 3-deep capture history and registered gap/normal checks.
// HWAG_GAP_GLITCH_FILTER_EN: edges arriving while timer < min_period are discarded.
module hwag_cap_history
  import hwag_pkg::*;
#(
  parameter int WIDTH = HWAG_WIDTH
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              cap_edge,
  input  logic              hist_clr,
  input  logic [WIDTH-1:0]  min_period,
  input  logic [WIDTH-1:0]  max_period,
  output logic [WIDTH-1:0]  period,
  output logic [HIST_W-1:0] hist_cnt,
  output logic              chk,
  output logic              gap,
  output logic              normal,
  output logic              stall,
  output logic              timeout
);

  logic [WIDTH-1:0] timer;
  logic [WIDTH-1:0] cap0;
  logic [WIDTH-1:0] cap1;
  logic [WIDTH-1:0] cap2;
  logic [WIDTH-1:0] timer_inc;
  logic [WIDTH-1:0] half_gap;
  logic             acc;
  logic             gap_d;
  logic             norm_d;

  // Checks use the post-shift view: new cap0 = timer, new cap1 = cap0, new cap2 = cap1.
  always_comb begin
    timer_inc = (&timer) ? timer : timer + WIDTH'(1);
`ifdef HWAG_GAP_GLITCH_FILTER_EN
    acc = cap_edge && (timer >= min_period);
`else
    acc = cap_edge;
`endif
    half_gap = cap0 >> 1;
    gap_d    = (timer < half_gap) && (cap1 < half_gap);
    norm_d   = (timer > min_period) && (cap0 > min_period) && (cap1 > min_period)
               && !((timer >= max_period) && (cap0 >= max_period));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer    <= '0;
      cap0     <= '0;
      cap1     <= '0;
      cap2     <= '0;
      hist_cnt <= '0;
      chk      <= 1'b0;
      gap      <= 1'b0;
      normal   <= 1'b0;
      stall    <= 1'b0;
      timeout  <= 1'b0;
    end else if (!enable) begin
      timer    <= '0;
      cap0     <= '0;
      cap1     <= '0;
      cap2     <= '0;
      hist_cnt <= '0;
      chk      <= 1'b0;
      gap      <= 1'b0;
      normal   <= 1'b0;
      stall    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      chk     <= acc;
      timeout <= 1'b0;
      if (acc) begin
        timer  <= WIDTH'(1);
        cap0   <= timer;
        cap1   <= cap0;
        cap2   <= cap1;
        gap    <= gap_d;
        normal <= norm_d;
        stall  <= 1'b0;
        if (hist_clr)
          hist_cnt <= HIST_W'(1);
        else if (hist_cnt != HIST_W'(HIST_MAX))
          hist_cnt <= hist_cnt + HIST_W'(1);
      end else if (timer > max_period) begin
        // Timer keeps running so the edge that ends the stall captures the real gap length.
        timer    <= timer_inc;
        cap0     <= '0;
        cap1     <= '0;
        cap2     <= '0;
        hist_cnt <= '0;
        stall    <= 1'b1;
        timeout  <= !stall;
      end else begin
        timer <= timer_inc;
        if (hist_clr)
          hist_cnt <= '0;
      end
    end
  end

  assign period = cap0;

endmodule

// File: rtl/hwag_gap_sync.sv
// Crank-wheel synchroniser: finds the missing-tooth gap, verifies it over one revolution, tracks tooth index.
// HWAG_GAP_GLITCH_FILTER_EN (in hwag_cap_history) enables short-edge rejection.
module hwag_gap_sync
  import hwag_pkg::*;
#(
  parameter int WIDTH   = HWAG_WIDTH,
  parameter int TOOTH_W = HWAG_TOOTH_W,
  parameter int TEETH   = HWAG_TEETH
) (
  input logic           clk,
  input logic           n_rst,
  hwag_gap_sync_if.slave bus
);

  localparam logic [TOOTH_W-1:0] LAST_TOOTH = TOOTH_W'(TEETH - 1);

  logic [HIST_W-1:0]  hist_cnt;
  logic               chk;
  logic               gap;
  logic               normal;
  logic               timeout;
  logic               hist_clr;
  logic               hist_stall;
  logic [WIDTH-1:0]   hist_period;
  hwag_state_t        state;
  hwag_state_t        nxt;
  logic [TOOTH_W-1:0] tooth;
  logic [TOOTH_W-1:0] tooth_nxt;
  logic               gap_ev;
  logic               err_ev;

  hwag_cap_history #(.WIDTH(WIDTH)) u_hist (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (bus.enable),
    .cap_edge   (bus.cap_edge),
    .hist_clr   (hist_clr),
    .min_period (bus.min_period),
    .max_period (bus.max_period),
    .period     (hist_period),
    .hist_cnt   (hist_cnt),
    .chk        (chk),
    .gap        (gap),
    .normal     (normal),
    .stall      (hist_stall),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      tooth <= '0;
    end else if (!bus.enable) begin
      state <= IDLE;
      tooth <= '0;
    end else begin
      state <= nxt;
      tooth <= tooth_nxt;
    end
  end

  // An abnormal period also drops the history count so IDLE waits for three fresh edges.
  always_comb begin
    nxt       = state;
    tooth_nxt = tooth;
    gap_ev    = 1'b0;
    err_ev    = 1'b0;
    hist_clr  = 1'b0;
    if (timeout) begin
      nxt       = IDLE;
      tooth_nxt = '0;
      err_ev    = (state == LOCKED);
    end else begin
      case (state)
        IDLE: begin
          if (hist_cnt == HIST_W'(HIST_MAX))
            nxt = SEARCH;
        end
        SEARCH: begin
          if (chk) begin
            if (!normal) begin
              err_ev    = 1'b1;
              nxt       = IDLE;
              tooth_nxt = '0;
              hist_clr  = 1'b1;
            end else if (gap) begin
              gap_ev    = 1'b1;
              tooth_nxt = '0;
              nxt       = VERIFY;
            end
          end
        end
        VERIFY, LOCKED: begin
          if (chk) begin
            if (!normal) begin
              err_ev    = 1'b1;
              nxt       = IDLE;
              tooth_nxt = '0;
              hist_clr  = 1'b1;
            end else if (tooth == LAST_TOOTH) begin
              if (gap) begin
                gap_ev    = 1'b1;
                tooth_nxt = '0;
                nxt       = LOCKED;
              end else begin
                err_ev = 1'b1;
                nxt    = SEARCH;
              end
            end else if (gap) begin
              err_ev = 1'b1;
              nxt    = SEARCH;
            end else begin
              tooth_nxt = tooth + TOOTH_W'(1);
            end
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.gap_pulse = gap_ev;
    bus.err       = err_ev;
    bus.locked    = (state == LOCKED);
    bus.tooth_num = tooth_nxt;
    bus.stall     = hist_stall;
    bus.period    = hist_period;
  end

endmodule

// File: tb/tb_hwag_gap_sync.sv
// Directed bench for hwag_gap_sync on a 60-2 wheel: tooth 100 clk, gap 300 clk, min 20, max 1000.
module tb_hwag_gap_sync;

  localparam int W  = 16;
  localparam int TW = 6;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  hwag_gap_sync_if #(.WIDTH(W), .TOOTH_W(TW)) bus ();

  hwag_gap_sync #(.WIDTH(W), .TOOTH_W(TW), .TEETH(58)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int gap_seen = 0;

  typedef struct {
    int reps;
    int per;
    int eg;
    int ee;
    int et;
    int el;
  } seg_t;

  seg_t tbl[21];

  always @(negedge clk) begin
    if (bus.err)       err_seen++;
    if (bus.gap_pulse) gap_seen++;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; the strobe lands k clocks after the previous edge.
  // Samples pulse outputs one cycle after the strobe, locked one cycle later.
  task automatic edge_after(input int k, output int g, output int e, output int t,
                            output int p, output int lk);
    repeat (k - 2) @(posedge clk);
    #1 bus.cap_edge = 1'b1;
    @(posedge clk);
    #1 bus.cap_edge = 1'b0;
    @(negedge clk);
    g = int'(bus.gap_pulse);
    e = int'(bus.err);
    t = int'(bus.tooth_num);
    p = int'(bus.period);
    @(negedge clk);
    lk = int'(bus.locked);
  endtask

  task automatic run_seg(input string nm, input int reps, input int per, input int eg,
                         input int ee, input int et, input int el, input int ep);
    int g, e, t, p, lk;
    g = 0; e = 0; t = 0; p = 0; lk = 0;
    for (int i = 0; i < reps; i++) edge_after(per, g, e, t, p, lk);
    check({nm, ".gap_pulse"}, g, eg);
    check({nm, ".err"}, e, ee);
    check({nm, ".tooth_num"}, t, et);
    check({nm, ".period"}, p, ep);
    check({nm, ".locked"}, lk, el);
  endtask

  task automatic run_range(input string nm, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      run_seg($sformatf("%s%0d", nm, i), tbl[i].reps, tbl[i].per, tbl[i].eg,
              tbl[i].ee, tbl[i].et, tbl[i].el, tbl[i].per);
  endtask

  initial begin
    int n;
    // sync from IDLE: fill history, find gap, verify over one revolution
    tbl[0]  = '{10, 100, 0, 0, 0, 0};
    tbl[1]  = '{1, 300, 0, 0, 0, 0};
    tbl[2]  = '{1, 100, 1, 0, 0, 0};
    tbl[3]  = '{56, 100, 0, 0, 56, 0};
    tbl[4]  = '{1, 300, 0, 0, 57, 0};
    tbl[5]  = '{1, 100, 1, 0, 0, 1};
    // two further clean revolutions while locked
    tbl[6]  = '{56, 100, 0, 0, 56, 1};
    tbl[7]  = '{1, 300, 0, 0, 57, 1};
    tbl[8]  = '{1, 100, 1, 0, 0, 1};
    tbl[9]  = '{56, 100, 0, 0, 56, 1};
    tbl[10] = '{1, 300, 0, 0, 57, 1};
    tbl[11] = '{1, 100, 1, 0, 0, 1};
    // early gap: would-be tooth 40 sees a gap
    tbl[12] = '{38, 100, 0, 0, 38, 1};
    tbl[13] = '{1, 300, 0, 0, 39, 1};
    tbl[14] = '{1, 100, 0, 1, 39, 0};
    // relock from SEARCH over two clean gaps
    tbl[15] = '{56, 100, 0, 0, 39, 0};
    tbl[16] = '{1, 300, 0, 0, 39, 0};
    tbl[17] = '{1, 100, 1, 0, 0, 0};
    tbl[18] = '{56, 100, 0, 0, 56, 0};
    tbl[19] = '{1, 300, 0, 0, 57, 0};
    tbl[20] = '{1, 100, 1, 0, 0, 1};

    bus.enable     = 1'b1;
    bus.cap_edge   = 1'b0;
    bus.min_period = 16'd20;
    bus.max_period = 16'd1000;

    #12;
    check("rst.period", int'(bus.period), 0);
    check("rst.locked", int'(bus.locked), 0);
    check("rst.stall", int'(bus.stall), 0);
    check("rst.tooth_num", int'(bus.tooth_num), 0);
    check("rst.gap_pulse", int'(bus.gap_pulse), 0);
    check("rst.err", int'(bus.err), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run_range("clean", 0, 11);
    check("clean.err_count", err_seen, 0);
    check("clean.gap_count", gap_seen, 4);
    run_range("extra", 12, 20);
    check("extra.err_count", err_seen, 1);

    // edges stop while locked
    run_seg("stall.pre", 5, 100, 0, 0, 5, 1, 100);
    n = 0;
    while (bus.stall == 1'b0 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("stall.delay", n, 1000);
    check("stall.err", int'(bus.err), 1);
    @(negedge clk);
    check("stall.locked", int'(bus.locked), 0);
    check("stall.err_once", int'(bus.err), 0);
    check("stall.held", int'(bus.stall), 1);
    run_seg("stall.clr", 1, 150, 0, 0, 0, 0, 1151);
    check("stall.cleared", int'(bus.stall), 0);
    run_seg("stall.hist", 2, 100, 0, 0, 0, 0, 100);
    run_seg("stall.s300", 1, 300, 0, 0, 0, 0, 300);
    run_seg("stall.search_gap", 1, 100, 1, 0, 0, 0, 100);
    run_range("stall.relock", 18, 20);

    // enable dropped mid-revolution
    run_seg("en.pre", 20, 100, 0, 0, 20, 1, 100);
    bus.enable = 1'b0;
    @(negedge clk);
    check("en.locked", int'(bus.locked), 0);
    check("en.tooth_num", int'(bus.tooth_num), 0);
    check("en.period", int'(bus.period), 0);
    check("en.stall", int'(bus.stall), 0);
    @(posedge clk);
    #1 bus.cap_edge = 1'b1;
    @(posedge clk);
    #1 bus.cap_edge = 1'b0;
    @(negedge clk);
    check("en.edge_ignored", int'(bus.period), 0);
    bus.enable = 1'b1;
    run_range("en.resync", 0, 5);

    // asynchronous reset between clock edges
    run_seg("rst2.pre", 7, 100, 0, 0, 7, 1, 100);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("rst2.locked", int'(bus.locked), 0);
    check("rst2.tooth_num", int'(bus.tooth_num), 0);
    check("rst2.period", int'(bus.period), 0);
    check("rst2.stall", int'(bus.stall), 0);
    check("rst2.err", int'(bus.err), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run_range("rst2.resync", 0, 5);

    // glitch 5 clocks after a tooth edge, real edge 95 clocks later
    run_seg("gl.pre", 10, 100, 0, 0, 10, 1, 100);
`ifdef HWAG_GAP_GLITCH_FILTER_EN
    run_seg("gl.edge", 1, 5, 0, 0, 10, 1, 100);
    run_seg("gl.next", 1, 95, 0, 0, 11, 1, 100);
`else
    run_seg("gl.edge", 1, 5, 0, 1, 0, 0, 5);
    run_seg("gl.next", 1, 95, 0, 0, 0, 0, 95);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
